// File: rtl/imem_loader.sv
// imem_loader
//
// Boot-time writer for the instruction memory. A byte stream arrives over a
// valid/ready handshake in the form LEN_LO, LEN_HI, N*4 data bytes (each
// word little-endian), then one checksum byte equal to the XOR of all data
// bytes. Data words are written to consecutive word addresses starting at 0.
// The core is held in reset until a load completes with a matching checksum.
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous, active-high reset
//   start         one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   byte_valid    source presents a byte on byte_data
//   byte_data     stream byte
//   byte_ready    loader accepts a byte this cycle (state-only decode)
//   imem_we       registered one-cycle write strobe
//   imem_addr     word address of the write, held until the next write
//   imem_wdata    write data, held until the next write
//   cpu_rst_hold  high keeps the core in reset; low only in DONE
//   done          load finished and checksum matched
//   err           length overflow or checksum mismatch
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for start
// LEN_LO   | waiting for word count bits 7:0
// LEN_HI   | waiting for word count bits 15:8, range check on transfer
// DATA     | assembling words, one write per 4 bytes
// CHECK    | waiting for the checksum byte
// DONE     | image loaded and verified, core released
// ERROR    | overflow or checksum mismatch, core held

module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_hold,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    // Capacity is 2^ADDR_W words, so a full image needs one extra count bit.
    localparam logic [16:0]       MAX_WORDS = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0]   WORD_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [7:0]        len_lo;
    logic [ADDR_W:0]   words_left;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_cnt;
    logic [7:0]        acc;
    logic [23:0]       word_buf;

    logic              xfer;
    logic              start_load;
    logic [16:0]       len_full;
    logic              len_ovf;
    logic              len_zero;
    logic              word_complete;
    logic              last_word;

    assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CHECK);
    assign xfer       = byte_valid & byte_ready;

    assign start_load = start && ((state == S_IDLE) || (state == S_DONE) ||
                                  (state == S_ERROR));

    assign len_full      = {1'b0, byte_data, len_lo};
    assign len_ovf       = len_full > MAX_WORDS;
    assign len_zero      = len_full == 17'd0;
    assign word_complete = byte_cnt == 2'd3;
    // Terminal count of the remaining-words down-counter.
    assign last_word     = words_left == WORD_ONE;

    assign done         = state == S_DONE;
    assign err          = state == S_ERROR;
    assign cpu_rst_hold = state != S_DONE;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if (len_ovf) begin
                        state_nxt = S_ERROR;
                    end else if (len_zero) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer && word_complete && last_word) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    state_nxt = (byte_data == acc) ? S_DONE : S_ERROR;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo     <= 8'd0;
            words_left <= '0;
            word_idx   <= '0;
            byte_cnt   <= 2'd0;
            acc        <= 8'd0;
            word_buf   <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;

            if (start_load) begin
                words_left <= '0;
                word_idx   <= '0;
                byte_cnt   <= 2'd0;
                acc        <= 8'd0;
            end

            case (state)
                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo <= byte_data;
                    end
                end
                S_LEN_HI: begin
                    // On overflow the loaded count is never used.
                    if (xfer) begin
                        words_left <= len_full[ADDR_W:0];
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        acc      <= acc ^ byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (word_complete) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx;
                            imem_wdata <= {byte_data, word_buf};
                            // word_idx may roll over after the very last
                            // word of a full image; it is not used again.
                            word_idx   <= word_idx + ADDR_ONE;
                            words_left <= words_left - WORD_ONE;
                        end else begin
                            // Bytes enter at the top and shift down, so the
                            // first byte of the word ends up in bits 7:0.
                            word_buf <= {byte_data, word_buf[23:8]};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
